// File: rtl/bp_cfg_regs_pkg.sv
// Shared types for the buffered configuration-register slave: command/response
// struct declaration macros (widths are parameter-dependent) and the address-decode enum.
`define BP_CFG_CMD_WIDTH(addr_w, data_w, tag_w) (1 + (addr_w) + (data_w) + (tag_w))
`define BP_CFG_RESP_WIDTH(data_w, tag_w) ((data_w) + (tag_w) + 1)

`define DECLARE_BP_CFG_CMD_S(addr_w, data_w, tag_w) \
  typedef struct packed {                             \
    logic                  wr;                        \
    logic [(addr_w)-1:0]   addr;                      \
    logic [(data_w)-1:0]   data;                      \
    logic [(tag_w)-1:0]    tag;                       \
  } bp_cfg_cmd_s

`define DECLARE_BP_CFG_RESP_S(data_w, tag_w) \
  typedef struct packed {                     \
    logic [(data_w)-1:0]   data;              \
    logic [(tag_w)-1:0]    tag;               \
    logic                  err;               \
  } bp_cfg_resp_s

package bp_cfg_regs_pkg;

  typedef enum logic [1:0] {
    e_cfg_rw,
    e_cfg_ro,
    e_cfg_err
  } bp_cfg_decode_e;

endpackage

// File: rtl/bp_cfg_regs_fifo.sv
// Circular FIFO with explicit occupancy count (any depth >= 2), registered
// full/empty flags, valid/ready enqueue and valid/yumi dequeue.
module bp_cfg_regs_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  // The enclosing logic only raises v_i when a slot is free or the head is
  // leaving this same cycle, so an enqueue into a full FIFO with a pop is legal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (v_i)
      wr_ptr_d = (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (yumi_i)
      rd_ptr_d = (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
    full_d  = (count_d == cnt_w_lp'(els_p));
    empty_d = (count_d == '0);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from the count, and data_o is gated while empty.
  always_ff @(posedge clk_i) begin
    if (v_i)
      mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = empty_q ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bp_cfg_buffered_regs.sv
// Buffered config-register slave: command FIFO -> single-cycle serial execute
// against RW registers / RO status window -> tagged response FIFO.
module bp_cfg_buffered_regs
  import bp_cfg_regs_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 8,
  parameter int tag_width_p  = 4,
  parameter int num_rw_p     = 8,
  parameter int num_ro_p     = 4,
  parameter int cmd_els_p    = 4,
  parameter int resp_els_p   = 4,
  parameter logic [num_rw_p*data_width_p-1:0] rw_reset_val_p = '0
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             cmd_v_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_wr_i,
  input  logic [addr_width_p-1:0]          cmd_addr_i,
  input  logic [data_width_p-1:0]          cmd_data_i,
  input  logic [tag_width_p-1:0]           cmd_tag_i,
  output logic                             resp_v_o,
  input  logic                             resp_yumi_i,
  output logic [data_width_p-1:0]          resp_data_o,
  output logic [tag_width_p-1:0]           resp_tag_o,
  output logic                             resp_err_o,
  output logic [num_rw_p*data_width_p-1:0] cfg_o,
  output logic [num_rw_p-1:0]              cfg_wr_pulse_o,
  input  logic [num_ro_p*data_width_p-1:0] status_i
);

  `DECLARE_BP_CFG_CMD_S(addr_width_p, data_width_p, tag_width_p);
  `DECLARE_BP_CFG_RESP_S(data_width_p, tag_width_p);

  localparam int cmd_width_lp  = `BP_CFG_CMD_WIDTH(addr_width_p, data_width_p, tag_width_p);
  localparam int resp_width_lp = `BP_CFG_RESP_WIDTH(data_width_p, tag_width_p);

  bp_cfg_cmd_s         cmd_in, cmd_head;
  bp_cfg_resp_s        resp_d, resp_head;
  logic                cmd_v, resp_ready, exec_fire;
  bp_cfg_decode_e      decode;
  logic [data_width_p-1:0] rd_data;

  logic [data_width_p-1:0] cfg_q [num_rw_p];
  logic [data_width_p-1:0] cfg_d [num_rw_p];
  logic [num_rw_p-1:0]     cfg_wr_pulse_q, cfg_wr_pulse_d;

  assign cmd_in = '{wr: cmd_wr_i, addr: cmd_addr_i, data: cmd_data_i, tag: cmd_tag_i};

  bp_cfg_regs_fifo #(.width_p(cmd_width_lp), .els_p(cmd_els_p)) cmd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (cmd_v_i & cmd_ready_o),
    .ready_o   (cmd_ready_o),
    .data_i    (cmd_in),
    .v_o       (cmd_v),
    .data_o    (cmd_head),
    .yumi_i    (exec_fire)
  );

  // A full response FIFO that is popping this cycle still has room for one more.
  assign exec_fire = cmd_v & (resp_ready | resp_yumi_i);

  always_comb begin
    decode  = e_cfg_err;
    rd_data = '0;
    for (int i = 0; i < num_rw_p; i++) begin
      if (cmd_head.addr == addr_width_p'(i)) begin
        decode  = e_cfg_rw;
        rd_data = cfg_q[i];
      end
    end
    for (int j = 0; j < num_ro_p; j++) begin
      if (cmd_head.addr == addr_width_p'(num_rw_p + j)) begin
        decode  = e_cfg_ro;
        rd_data = status_i[j*data_width_p +: data_width_p];
      end
    end
  end

  always_comb begin
    cfg_d          = cfg_q;
    cfg_wr_pulse_d = '0;
    resp_d.tag     = cmd_head.tag;
    resp_d.err     = (decode == e_cfg_err) | (cmd_head.wr & (decode == e_cfg_ro));
    resp_d.data    = (!cmd_head.wr && decode != e_cfg_err) ? rd_data : '0;
    if (exec_fire && cmd_head.wr && decode == e_cfg_rw) begin
      for (int i = 0; i < num_rw_p; i++) begin
        if (cmd_head.addr == addr_width_p'(i)) begin
          cfg_d[i]          = cmd_head.data;
          cfg_wr_pulse_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_rw_p; i++)
        cfg_q[i] <= rw_reset_val_p[i*data_width_p +: data_width_p];
      cfg_wr_pulse_q <= '0;
    end else begin
      cfg_q          <= cfg_d;
      cfg_wr_pulse_q <= cfg_wr_pulse_d;
    end
  end

  bp_cfg_regs_fifo #(.width_p(resp_width_lp), .els_p(resp_els_p)) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (exec_fire),
    .ready_o   (resp_ready),
    .data_i    (resp_d),
    .v_o       (resp_v_o),
    .data_o    (resp_head),
    .yumi_i    (resp_yumi_i)
  );

  assign resp_data_o    = resp_head.data;
  assign resp_tag_o     = resp_head.tag;
  assign resp_err_o     = resp_head.err;
  assign cfg_wr_pulse_o = cfg_wr_pulse_q;

  for (genvar g = 0; g < num_rw_p; g++) begin : g_cfg_out
    assign cfg_o[g*data_width_p +: data_width_p] = cfg_q[g];
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    resp_yumi_i |-> resp_v_o);

endmodule

// File: tb/tb_bp_cfg_buffered_regs.sv
// Directed bench for bp_cfg_buffered_regs: expected responses go into a queue
// when commands are driven and are popped/compared as the DUT returns them.
module tb_bp_cfg_buffered_regs;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int NUM_RW = 8;
  localparam int NUM_RO = 4;
  localparam logic [NUM_RW*DW-1:0] RST_VAL = {
    64'h1007, 64'h1006, 64'h1005, 64'h1004,
    64'h1003, 64'h1002, 64'h1001, 64'h1000};

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  logic                  clk_i = 1'b0;
  logic                  reset_n_i = 1'b1;
  logic                  cmd_v_i = 1'b0;
  logic                  cmd_ready_o;
  logic                  cmd_wr_i = 1'b0;
  logic [AW-1:0]         cmd_addr_i = '0;
  logic [DW-1:0]         cmd_data_i = '0;
  logic [TW-1:0]         cmd_tag_i = '0;
  logic                  resp_v_o;
  logic                  resp_yumi_i;
  logic [DW-1:0]         resp_data_o;
  logic [TW-1:0]         resp_tag_o;
  logic                  resp_err_o;
  logic [NUM_RW*DW-1:0]  cfg_o;
  logic [NUM_RW-1:0]     cfg_wr_pulse_o;
  logic [NUM_RO*DW-1:0]  status_i;

  logic                  yumi_en = 1'b0;
  logic [DW-1:0]         exp_cfg [NUM_RW];
  logic [DW-1:0]         status_vals [NUM_RO];
  exp_t                  sb [$];
  int                    pop_cyc_q [$];
  int                    n_checks = 0;
  int                    n_errors = 0;
  int                    cyc = 0;
  exp_t                  mon_exp;

  assign resp_yumi_i = yumi_en & resp_v_o;

  bp_cfg_buffered_regs #(
    .data_width_p(DW), .addr_width_p(AW), .tag_width_p(TW),
    .num_rw_p(NUM_RW), .num_ro_p(NUM_RO), .cmd_els_p(4), .resp_els_p(4),
    .rw_reset_val_p(RST_VAL)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_tag_i(cmd_tag_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_data_o(resp_data_o),
    .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o),
    .cfg_o(cfg_o), .cfg_wr_pulse_o(cfg_wr_pulse_o), .status_i(status_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_cfg(input string name);
    for (int i = 0; i < NUM_RW; i++)
      check(name, cfg_o[i*DW +: DW], exp_cfg[i]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_RW; i++) exp_cfg[i] = RST_VAL[i*DW +: DW];
  endtask

  // Reference behaviour of one command, applied in issue order.
  task automatic expect_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [TW-1:0] tag);
    exp_t e;
    e.tag = tag; e.data = '0; e.err = 1'b0;
    if (int'(addr) < NUM_RW) begin
      if (wr) exp_cfg[addr] = data;
      else    e.data = exp_cfg[addr];
    end else if (int'(addr) < NUM_RW + NUM_RO) begin
      if (wr) e.err = 1'b1;
      else    e.data = status_vals[int'(addr) - NUM_RW];
    end else begin
      e.err = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [TW-1:0] tag);
    logic rdy, accepted;
    expect_cmd(wr, addr, data, tag);
    cmd_v_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr; cmd_data_i = data; cmd_tag_i = tag;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk_i); rdy = cmd_ready_o;
      @(posedge clk_i); #1; accepted = rdy;
    end
    cmd_v_i = 1'b0;
    if (!accepted) check("send_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !resp_v_o) break;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i && resp_v_o && yumi_en) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(resp_v_o), 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("resp_data", resp_data_o, mon_exp.data);
        check("resp_tag", 64'(resp_tag_o), 64'(mon_exp.tag));
        check("resp_err", 64'(resp_err_o), 64'(mon_exp.err));
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    int t0;
    for (int j = 0; j < NUM_RO; j++) status_vals[j] = 64'hAAAA_0000 + 64'(j);
    status_vals[1] = 64'h1234;
    for (int j = 0; j < NUM_RO; j++) status_i[j*DW +: DW] = status_vals[j];
    reset_model();

    // Reset values
    #1 reset_n_i = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_resp_v", 64'(resp_v_o), 64'd0);
    check("rst_resp_data", resp_data_o, 64'd0);
    check("rst_resp_tag", 64'(resp_tag_o), 64'd0);
    check("rst_resp_err", 64'(resp_err_o), 64'd0);
    check("rst_pulse", 64'(cfg_wr_pulse_o), 64'd0);
    check_cfg("rst_cfg");
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    yumi_en = 1'b1;

    // Write latency and pulse alignment
    send(1'b1, 8'd2, 64'hDEAD_BEEF, 4'd3);
    @(negedge clk_i);
    check("lat_n1_resp_v", 64'(resp_v_o), 64'd0);
    check("lat_n1_pulse", 64'(cfg_wr_pulse_o), 64'd0);
    @(negedge clk_i);
    check("lat_n2_resp_v", 64'(resp_v_o), 64'd1);
    check("wr_pulse", 64'(cfg_wr_pulse_o), 64'h4);
    check("wr_cfg2", cfg_o[2*DW +: DW], 64'hDEAD_BEEF);
    @(negedge clk_i);
    check("wr_pulse_clear", 64'(cfg_wr_pulse_o), 64'd0);
    wait_drain();

    // RO read, RO write error, out-of-range error, then in-order RW read
    @(posedge clk_i); #1;
    send(1'b0, 8'd9, 64'd0, 4'd5);
    send(1'b1, 8'd9, 64'hFFFF, 4'd6);
    send(1'b0, 8'd200, 64'd0, 4'd7);
    send(1'b0, 8'd0, 64'd0, 4'd8);
    wait_drain();
    check_cfg("ro_write_no_change");

    // Back-pressure: 8 commands fill both FIFOs, the 9th waits
    @(posedge clk_i); #1;
    yumi_en = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i), 64'd0, TW'(i));
    @(negedge clk_i);
    check("full_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("full_resp_v", 64'(resp_v_o), 64'd1);
    cmd_v_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 8'd8; cmd_tag_i = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_cmd_ready", 64'(cmd_ready_o), 64'd0);
    end
    @(posedge clk_i); #1;
    yumi_en = 1'b1;
    send(1'b0, 8'd8, 64'd0, 4'd8);
    wait_drain();

    // Back-to-back writes with yumi held high
    @(posedge clk_i); #1;
    pop_cyc_q.delete();
    t0 = cyc;
    for (int i = 0; i < 16; i++)
      send(1'b1, AW'(i % NUM_RW), {$urandom(), $urandom()}, TW'(i));
    check("b2b_accept_cycles", 64'(cyc - t0), 64'd16);
    wait_drain();
    check("b2b_resp_count", 64'(pop_cyc_q.size()), 64'd16);
    if (pop_cyc_q.size() == 16)
      check("b2b_resp_span", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);
    check_cfg("b2b_cfg");

    // Reset with commands in flight
    @(posedge clk_i); #1;
    yumi_en = 1'b0;
    send(1'b1, 8'd5, 64'h5555, 4'd1);
    send(1'b1, 8'd6, 64'h6666, 4'd2);
    send(1'b1, 8'd7, 64'h7777, 4'd3);
    reset_n_i = 1'b0;
    sb.delete();
    reset_model();
    #1;
    check("mid_rst_resp_v", 64'(resp_v_o), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check_cfg("mid_rst_cfg");
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    yumi_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("post_rst_no_stale", 64'(resp_v_o), 64'd0);
    end
    @(posedge clk_i); #1;
    send(1'b0, 8'd5, 64'd0, 4'd9);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
